// File: rtl/ahb_slv_resp.sv
// AHB-Lite slave responder backed by a word-organised SRAM, with programmable
// wait states and a two-cycle ERROR response for illegal transfers.
module ahb_slv_resp #(
  parameter int unsigned ADDR_W    = 14,
  parameter int unsigned MEM_BYTES = 4096,
  parameter int unsigned WAIT_CYC  = 0
) (
  input  logic        hclk,
  input  logic        hreset,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [2:0]  hburst,
  input  logic [3:0]  hprot,
  input  logic [31:0] hwdata,
  input  logic        hready_i,
  output logic [31:0] hrdata,
  output logic        hready_o,
  output logic [1:0]  hresp
);

  localparam int unsigned MEM_WORDS = MEM_BYTES / 4;
  localparam int unsigned IDX_W     = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR1, S_ERR2} state_t;

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             pend_wr_q, pend_wr_d;
  logic             pend_rd_q, pend_rd_d;
  logic [IDX_W+1:0] dp_off_q, dp_off_d;
  logic [1:0]       dp_size_q, dp_size_d;
  logic [31:0]      hrdata_q, hrdata_d;
  logic [31:0]      rd_buf_q, rd_buf_d;

  logic [31:0]      mem [MEM_WORDS];

  logic [ADDR_W-1:0] acc_off;
  logic [IDX_W-1:0]  acc_idx;
  logic [IDX_W-1:0]  wr_idx;
  logic              accept;
  logic              acc_err;
  logic              write_now;
  logic [3:0]        wr_be;
  logic [31:0]       fwd_word;
  logic              unused_ok;

  assign unused_ok = ^{haddr[31:ADDR_W], hburst, hprot};

  assign acc_off   = haddr[ADDR_W-1:0];
  assign acc_idx   = acc_off[IDX_W+1:2];
  assign wr_idx    = dp_off_q[IDX_W+1:2];
  assign accept    = hsel & htrans[1] & hready_i;
  assign acc_err   = (hsize > 3'd2)
                   | ((hsize == 3'd1) & acc_off[0])
                   | ((hsize == 3'd2) & (|acc_off[1:0]))
                   | (32'(acc_off) >= MEM_BYTES);
  // A pending write completes in the cycle after its waits, which is always IDLE
  assign write_now = pend_wr_q & (state_q == S_IDLE);

  always_comb begin
    unique case (dp_size_q)
      2'd0:    wr_be = 4'b0001 << dp_off_q[1:0];
      2'd1:    wr_be = dp_off_q[1] ? 4'b1100 : 4'b0011;
      default: wr_be = 4'b1111;
    endcase
  end

  // Read-at-accept with the completing write's lanes merged in for the same word
  always_comb begin
    fwd_word = mem[acc_idx];
    if (write_now && (wr_idx == acc_idx)) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) fwd_word[8*b +: 8] = hwdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge hclk) begin
    if (write_now) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) mem[wr_idx][8*b +: 8] <= hwdata[8*b +: 8];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_wr_d = pend_wr_q;
    pend_rd_d = pend_rd_q;
    dp_off_d  = dp_off_q;
    dp_size_d = dp_size_q;
    hrdata_d  = hrdata_q;
    rd_buf_d  = rd_buf_q;
    unique case (state_q)
      S_WAIT: begin
        if (cnt_q == 4'd1) begin
          state_d = S_IDLE;
          if (pend_rd_q) begin
            hrdata_d  = rd_buf_q;
            pend_rd_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_ERR1: state_d = S_ERR2;
      default: begin
        state_d   = S_IDLE;
        pend_wr_d = 1'b0;
        pend_rd_d = 1'b0;
        if (accept) begin
          if (acc_err) begin
            state_d = S_ERR1;
          end else begin
            pend_wr_d = hwrite;
            dp_off_d  = acc_off[IDX_W+1:0];
            dp_size_d = hsize[1:0];
            if (WAIT_CYC == 0) begin
              if (!hwrite) hrdata_d = fwd_word;
            end else begin
              state_d   = S_WAIT;
              cnt_d     = 4'(WAIT_CYC);
              pend_rd_d = ~hwrite;
              rd_buf_d  = fwd_word;
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      pend_wr_q <= 1'b0;
      pend_rd_q <= 1'b0;
      dp_off_q  <= '0;
      dp_size_q <= 2'd0;
      hrdata_q  <= 32'd0;
      rd_buf_q  <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_wr_q <= pend_wr_d;
      pend_rd_q <= pend_rd_d;
      dp_off_q  <= dp_off_d;
      dp_size_q <= dp_size_d;
      hrdata_q  <= hrdata_d;
      rd_buf_q  <= rd_buf_d;
    end
  end

  assign hrdata   = hrdata_q;
  assign hready_o = ~((state_q == S_WAIT) | (state_q == S_ERR1));
  assign hresp    = ((state_q == S_ERR1) | (state_q == S_ERR2)) ? 2'b01 : 2'b00;

endmodule

// File: tb/tb_ahb_slv_resp.sv
// Bench for ahb_slv_resp: one instance with no wait states and one with three,
// checked against a byte-array memory model and the transfer rules.
module tb_ahb_slv_resp;

  logic        hclk = 1'b0;
  logic        hreset;
  logic        hsel0, hsel3;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic [31:0] hwdata;
  logic [31:0] hrdata0, hrdata3;
  logic        hready0, hready3;
  logic [1:0]  hresp0, hresp3;

  int total = 0;
  int bad   = 0;

  logic [7:0] mdl [2][256];

  always #5 hclk = ~hclk;

  ahb_slv_resp #(.ADDR_W(14), .MEM_BYTES(4096), .WAIT_CYC(0)) dut0 (
    .hclk(hclk), .hreset(hreset), .hsel(hsel0), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hprot(hprot), .hwdata(hwdata),
    .hready_i(hready0), .hrdata(hrdata0), .hready_o(hready0), .hresp(hresp0)
  );

  ahb_slv_resp #(.ADDR_W(14), .MEM_BYTES(4096), .WAIT_CYC(3)) dut3 (
    .hclk(hclk), .hreset(hreset), .hsel(hsel3), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hprot(hprot), .hwdata(hwdata),
    .hready_i(hready3), .hrdata(hrdata3), .hready_o(hready3), .hresp(hresp3)
  );

  function automatic logic cur_ready(int d);
    return (d == 0) ? hready0 : hready3;
  endfunction

  function automatic logic [1:0] cur_resp(int d);
    return (d == 0) ? hresp0 : hresp3;
  endfunction

  function automatic logic [31:0] cur_rdata(int d);
    return (d == 0) ? hrdata0 : hrdata3;
  endfunction

  function automatic int exp_waits(int d);
    return (d == 0) ? 0 : 3;
  endfunction

  function automatic logic [31:0] mk_addr(logic [13:0] off);
    logic [31:0] r;
    r = $urandom();
    return {r[31:14], off};
  endfunction

  function automatic bit is_err(logic [2:0] size, logic [13:0] off);
    int n;
    n = int'(off);
    if (size > 3'd2) return 1'b1;
    if (size == 3'd1 && (n % 2) != 0) return 1'b1;
    if (size == 3'd2 && (n % 4) != 0) return 1'b1;
    return n >= 4096;
  endfunction

  function automatic logic [31:0] mdl_word(int d, logic [13:0] off);
    int b;
    b = int'(off) / 4 * 4;
    return {mdl[d][b+3], mdl[d][b+2], mdl[d][b+1], mdl[d][b]};
  endfunction

  task automatic mdl_write(int d, logic [13:0] off, logic [2:0] size, logic [31:0] wdata);
    int a;
    for (int i = 0; i < (1 << size); i++) begin
      a = int'(off) + i;
      mdl[d][a] = wdata[8*(a % 4) +: 8];
    end
  endtask

  task automatic bus_idle();
    hsel0  = 1'b0;
    hsel3  = 1'b0;
    htrans = 2'b00;
  endtask

  // Single non-pipelined transfer; entered and left at #1 after a rising edge
  task automatic run_xfer(input int d, input bit wr, input logic [31:0] addr,
                          input logic [2:0] size, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic [1:0] first_resp,
                          output logic [1:0] last_resp, output int waits);
    haddr  = addr;
    hwrite = wr;
    hsize  = size;
    htrans = 2'b10;
    hsel0  = (d == 0);
    hsel3  = (d != 0);
    @(posedge hclk); #1;
    bus_idle();
    hwdata     = wdata;
    waits      = 0;
    first_resp = cur_resp(d);
    while (cur_ready(d) !== 1'b1 && waits <= 20) begin
      waits++;
      @(posedge hclk); #1;
    end
    last_resp = cur_resp(d);
    rdata     = cur_rdata(d);
    @(posedge hclk); #1;
  endtask

  task automatic test_reset();
    hreset = 1'b1;
    bus_idle();
    repeat (3) @(posedge hclk);
    #1;
    for (int d = 0; d < 2; d++) begin
      total++;
      if (cur_ready(d) !== 1'b1) begin
        bad++;
        $display("FAIL reset_hready d=%0d got=%b want=1", d, cur_ready(d));
      end
      total++;
      if (cur_resp(d) !== 2'b00) begin
        bad++;
        $display("FAIL reset_hresp d=%0d got=%b want=00", d, cur_resp(d));
      end
      total++;
      if (cur_rdata(d) !== 32'd0) begin
        bad++;
        $display("FAIL reset_hrdata d=%0d got=%h want=0", d, cur_rdata(d));
      end
    end
    hreset = 1'b0;
    @(posedge hclk); #1;
  endtask

  task automatic init_mem();
    logic [31:0] rd, wd;
    logic [1:0]  fr, lr;
    int          w;
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 64; i++) begin
        wd = $urandom();
        run_xfer(d, 1'b1, mk_addr(14'(i * 4)), 3'd2, wd, rd, fr, lr, w);
        mdl_write(d, 14'(i * 4), 3'd2, wd);
      end
    end
  endtask

  task automatic test_basic();
    logic [31:0] rd;
    logic [1:0]  fr, lr;
    int          w;
    run_xfer(0, 1'b1, 32'h0000_0010, 3'd2, 32'hDEAD_BEEF, rd, fr, lr, w);
    mdl_write(0, 14'h010, 3'd2, 32'hDEAD_BEEF);
    total++;
    if (w !== 0 || fr !== 2'b00 || lr !== 2'b00) begin
      bad++;
      $display("FAIL basic_write waits=%0d resp=%b/%b want 0 00/00", w, fr, lr);
    end
    @(posedge hclk); #1;
    run_xfer(0, 1'b0, 32'h0000_0010, 3'd2, 32'h0, rd, fr, lr, w);
    total++;
    if (w !== 0 || lr !== 2'b00 || rd !== 32'hDEAD_BEEF) begin
      bad++;
      $display("FAIL basic_read waits=%0d resp=%b data=%h want 0 00 deadbeef", w, lr, rd);
    end
  endtask

  task automatic test_byte_lane();
    logic [31:0] rd;
    logic [1:0]  fr, lr;
    int          w;
    for (int d = 0; d < 2; d++) begin
      run_xfer(d, 1'b1, mk_addr(14'h010), 3'd2, 32'h1122_3344, rd, fr, lr, w);
      mdl_write(d, 14'h010, 3'd2, 32'h1122_3344);
      run_xfer(d, 1'b1, mk_addr(14'h013), 3'd0, 32'hAA00_0000, rd, fr, lr, w);
      mdl_write(d, 14'h013, 3'd0, 32'hAA00_0000);
      total++;
      if (w !== exp_waits(d) || lr !== 2'b00) begin
        bad++;
        $display("FAIL byte_write d=%0d waits=%0d resp=%b want %0d 00", d, w, lr, exp_waits(d));
      end
      run_xfer(d, 1'b0, mk_addr(14'h010), 3'd2, 32'h0, rd, fr, lr, w);
      total++;
      if (rd !== 32'hAA22_3344) begin
        bad++;
        $display("FAIL byte_lane d=%0d got=%h want=aa223344", d, rd);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd, wd, exp;
    logic [1:0]  fr, lr;
    logic [2:0]  size;
    logic [13:0] off;
    int          w;
    run_xfer(0, 1'b1, 32'h0000_0020, 3'd2, 32'h0, rd, fr, lr, w);
    mdl_write(0, 14'h020, 3'd2, 32'h0);
    for (int i = 0; i < 31; i++) begin
      if (i == 0) begin
        off  = 14'h020;
        size = 3'd2;
        wd   = 32'h5A5A_5A5A;
      end else begin
        size = 3'($urandom_range(0, 2));
        off  = 14'($urandom_range(0, 255)) & ~((14'd1 << size) - 14'd1);
        wd   = $urandom();
      end
      haddr  = mk_addr(off);
      hwrite = 1'b1;
      hsize  = size;
      htrans = 2'b10;
      hsel0  = 1'b1;
      @(posedge hclk); #1;
      mdl_write(0, off, size, wd);
      exp    = mdl_word(0, off);
      haddr  = mk_addr(off & ~14'd3);
      hwrite = 1'b0;
      hsize  = 3'd2;
      htrans = 2'b10;
      hwdata = wd;
      total++;
      if (hready0 !== 1'b1) begin
        bad++;
        $display("FAIL b2b_wr_ready i=%0d got=%b want=1", i, hready0);
      end
      @(posedge hclk); #1;
      bus_idle();
      total++;
      if (hready0 !== 1'b1 || hresp0 !== 2'b00 || hrdata0 !== exp) begin
        bad++;
        $display("FAIL b2b_fwd i=%0d ready=%b resp=%b data=%h want 1 00 %h",
                 i, hready0, hresp0, hrdata0, exp);
      end
      @(posedge hclk); #1;
    end
  endtask

  task automatic test_wait();
    logic [31:0] rd;
    logic [1:0]  fr, lr;
    int          w;
    run_xfer(1, 1'b0, mk_addr(14'h010), 3'd2, 32'h0, rd, fr, lr, w);
    total++;
    if (w !== 3 || fr !== 2'b00 || lr !== 2'b00 || rd !== 32'hAA22_3344) begin
      bad++;
      $display("FAIL wait_read waits=%0d resp=%b/%b data=%h want 3 00/00 aa223344", w, fr, lr, rd);
    end
  endtask

  task automatic test_error();
    logic [31:0] rd, prev;
    logic [1:0]  fr, lr;
    logic [13:0] offs [3];
    logic [2:0]  sizes [3];
    int          w;
    offs  = '{14'h1000, 14'h0001, 14'h0000};
    sizes = '{3'd2, 3'd1, 3'd3};
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 3; k++) begin
        prev = cur_rdata(d);
        run_xfer(d, 1'b1, mk_addr(offs[k]), sizes[k], 32'hFFFF_FFFF, rd, fr, lr, w);
        total++;
        if (w !== 1 || fr !== 2'b01 || lr !== 2'b01 || rd !== prev) begin
          bad++;
          $display("FAIL error_resp d=%0d k=%0d waits=%0d resp=%b/%b data=%h want 1 01/01 %h",
                   d, k, w, fr, lr, rd, prev);
        end
      end
      run_xfer(d, 1'b0, mk_addr(14'h000), 3'd2, 32'h0, rd, fr, lr, w);
      total++;
      if (rd !== mdl_word(d, 14'h000)) begin
        bad++;
        $display("FAIL error_mem d=%0d got=%h want=%h", d, rd, mdl_word(d, 14'h000));
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd, old;
    logic [1:0]  fr, lr;
    int          w;
    old    = mdl_word(1, 14'h030);
    haddr  = mk_addr(14'h030);
    hwrite = 1'b1;
    hsize  = 3'd2;
    htrans = 2'b10;
    hsel3  = 1'b1;
    @(posedge hclk); #1;
    bus_idle();
    hwdata = ~old;
    @(posedge hclk); #1;
    total++;
    if (hready3 !== 1'b0) begin
      bad++;
      $display("FAIL midrst_wait got=%b want=0", hready3);
    end
    hreset = 1'b1;
    #1;
    total++;
    if (hready3 !== 1'b1 || hresp3 !== 2'b00 || hrdata3 !== 32'd0) begin
      bad++;
      $display("FAIL midrst_out ready=%b resp=%b data=%h want 1 00 0", hready3, hresp3, hrdata3);
    end
    @(posedge hclk); #1;
    hreset = 1'b0;
    repeat (4) @(posedge hclk);
    #1;
    run_xfer(1, 1'b0, mk_addr(14'h030), 3'd2, 32'h0, rd, fr, lr, w);
    total++;
    if (w !== 3 || lr !== 2'b00 || rd !== old) begin
      bad++;
      $display("FAIL midrst_mem waits=%0d resp=%b data=%h want 3 00 %h", w, lr, rd, old);
    end
  endtask

  task automatic test_random();
    logic [31:0] rd, wd, prev, exp;
    logic [1:0]  fr, lr, expr;
    logic [2:0]  size;
    logic [13:0] off;
    int          w, d, expw;
    bit          wr, err;
    for (int i = 0; i < 200; i++) begin
      d  = $urandom_range(0, 1);
      wr = 1'($urandom_range(0, 1));
      wd = $urandom();
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 2))
          0: begin
            size = 3'($urandom_range(3, 7));
            off  = 14'($urandom_range(0, 255));
          end
          1: begin
            size = 3'($urandom_range(1, 2));
            off  = 14'($urandom_range(0, 63) * 4);
            off  = off + ((size == 3'd1) ? 14'(1 + 2 * $urandom_range(0, 1))
                                         : 14'($urandom_range(1, 3)));
          end
          default: begin
            size = 3'd2;
            off  = 14'($urandom_range(4096, 16383)) & ~14'd3;
          end
        endcase
      end else begin
        size = 3'($urandom_range(0, 2));
        off  = 14'($urandom_range(0, 255)) & ~((14'd1 << size) - 14'd1);
      end
      err  = is_err(size, off);
      prev = cur_rdata(d);
      exp  = err ? prev : (wr ? prev : mdl_word(d, off));
      expw = err ? 1 : exp_waits(d);
      expr = err ? 2'b01 : 2'b00;
      run_xfer(d, wr, mk_addr(off), size, wd, rd, fr, lr, w);
      if (!err && wr) mdl_write(d, off, size, wd);
      total++;
      if (w !== expw || fr !== expr || lr !== expr) begin
        bad++;
        $display("FAIL rand_resp i=%0d d=%0d waits=%0d resp=%b/%b want %0d %b",
                 i, d, w, fr, lr, expw, expr);
      end
      total++;
      if (rd !== exp) begin
        bad++;
        $display("FAIL rand_data i=%0d d=%0d off=%h got=%h want=%h", i, d, off, rd, exp);
      end
    end
  endtask

  initial begin
    hreset = 1'b1;
    hsel0  = 1'b0;
    hsel3  = 1'b0;
    haddr  = 32'd0;
    htrans = 2'b00;
    hwrite = 1'b0;
    hsize  = 3'd2;
    hburst = 3'd0;
    hprot  = 4'h3;
    hwdata = 32'd0;
    test_reset();
    init_mem();
    test_basic();
    test_byte_lane();
    test_back_to_back();
    test_wait();
    test_error();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/ahb_slv_resp.md
Name: ahb_slv_resp

Overview:
AHB-Lite slave responder: the far end of the master-side AHB interfaces driven into the bus matrix. Sits on a matrix slave port (or directly facing an AHB master interface in unit benches). Backs transfers with an internal word-organised SRAM, inserts programmable wait states, and returns a two-cycle ERROR response for illegal transfers. Provides a deterministic, cycle-exact target for checking master-side drivers and matrix routing.

Parameters:
ADDR_W, 14, number of haddr offset bits decoded (offset = haddr[ADDR_W-1:0]); haddr[31:ADDR_W] ignored (bus matrix decodes)
MEM_BYTES, 4096, backed memory size in bytes, multiple of 4, at most 2^ADDR_W; offset >= MEM_BYTES is an error
WAIT_CYC, 0, wait states per OKAY transfer, 0..15

Ports:
hclk  in  1  bus clock, all logic on rising edge
hreset  in  1  asynchronous reset, active-high
hsel  in  1  slave select
haddr  in  32  address, address phase
htrans  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
hwrite  in  1  1 = write
hsize  in  3  0 byte, 1 halfword, 2 word
hburst  in  3  accepted, not used for addressing (every beat carries its own haddr)
hprot  in  4  accepted, ignored
hwdata  in  32  write data, data phase
hready_i  in  1  bus HREADY (tie to hready_o in single-slave benches)
hrdata  out  32  read data, valid when hready_o=1 in a read data phase
hready_o  out  1  transfer-done / slave-ready
hresp  out  2  00 OKAY, 01 ERROR

Behaviour:
- Reset (asynchronous, hreset=1): state IDLE, hready_o=1, hresp=00, hrdata=0, wait counter=0, pending-write flag=0. Memory contents are not cleared.
- Accept: on a rising edge with hsel & htrans[1] & hready_i=1. Capture offset, hwrite, and hsize into data-phase registers.
- IDLE/BUSY, or hsel=0 with hready_i=1: next cycle is hready_o=1, hresp=00, with no memory effect.
- Error check at accept. A transfer is an error if any of these hold:
  - hsize > 2;
  - misaligned: halfword with offset[0]=1, or word with offset[1:0]!=0;
  - offset >= MEM_BYTES.
- Error response: ERR1 (hready_o=0, hresp=01), then ERR2 (hready_o=1, hresp=01), then back to IDLE/ACCEPT. No memory write. hrdata holds its previous value. A transfer presented during ERR2 with hready_i=1 is accepted normally.
- States: IDLE, WAIT, ERR1, ERR2.
  - IDLE → WAIT on a legal accept with WAIT_CYC>0.
  - IDLE → ERR1 on an illegal accept.
  - A legal accept with WAIT_CYC=0 stays in IDLE and completes in the next cycle.
  - WAIT holds hready_o=0 for exactly WAIT_CYC cycles, then one completion cycle with hready_o=1, hresp=00.
  - ERR1 → ERR2 → IDLE.
- Latency: a legal transfer completes WAIT_CYC+1 cycles after its accept edge.
- Writes:
  - hwdata is sampled on the completion edge (hready_o=1).
  - Byte lanes are little-endian. Lane select: byte = offset[1:0], halfword = offset[1]*2.
  - Only the addressed lanes are written.
- Reads:
  - The SRAM word is read at accept and registered into hrdata.
  - The full 32-bit word is returned regardless of hsize.
  - hrdata is held until the next read completion.
- Write-read forwarding: if a read is accepted on the same edge a write to the same word completes, hrdata = stored word with the written lanes replaced by the new hwdata lanes.
- Pipelining: a new address phase overlaps the current data phase. Accept is only possible when hready_i=1, so wait and ERR1 cycles block new accepts.
- Reset mid-transfer: the pending transfer is abandoned and any uncompleted write is dropped. Outputs return to reset values immediately.

Test Plan:
1. WAIT_CYC=0: write 0xDEADBEEF to 0x010, then read 0x010 (idle between) → hrdata=0xDEADBEEF; hready_o stays 1 throughout; hresp=00.
2. Write word 0x11223344 @0x010, byte 0xAA (hsize=0, hwdata=0xAA000000) @0x013, read 0x010 → 0xAA223344.
3. Back-to-back NONSEQ write 0x5A5A5A5A @0x020 then read @0x020, no idle → read completes next cycle with 0x5A5A5A5A (forwarding path).
4. WAIT_CYC=3: read 0x010 → hready_o=0 for exactly 3 cycles, then 1 with hrdata=0xAA223344, hresp=00.
5. Illegal transfers → each gives hready_o=0/hresp=01, then hready_o=1/hresp=01; memory unchanged, confirmed by reading 0x000 back.
   - word write @0x1000 (offset ≥ MEM_BYTES);
   - halfword write @0x001 (misaligned);
   - hsize=3 @0x000.
6. WAIT_CYC=3: assert hreset for 1 cycle during the 2nd wait cycle of a write to 0x030 → hready_o=1, hresp=00 immediately; a later read of 0x030 returns the pre-write value.
